pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the next-generation KGP-RISC core. It holds the current instruction address and computes the next one itself: sequential increment, stall hold, branch/jump redirect, and call/return. Call/return use an internal return-address stack (RAS). It feeds instruction memory and the branch/link datapath in place of a bare PC register.

Parameters:
- ADDR_W, 32, address width in bits
- INCR, 4, sequential increment in address units
- RESET_VECTOR, 0, value loaded into pc on reset
- RAS_DEPTH, 4, number of RAS entries (power of two, at least 2)
- TRAP_VECTOR, 32'h0000_0080, pc value on misaligned redirect (optional feature only)

Ports:
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- stall  in  1  hold pc and RAS this cycle
- redirect  in  1  take redirect_target (branch/jump/call)
- redirect_target  in  ADDR_W  redirect destination
- call  in  1  with redirect: push pc_plus onto the RAS
- ret  in  1  pop the RAS into pc
- pc  out  ADDR_W  current instruction address (registered)
- pc_plus  out  ADDR_W  pc+INCR (combinational, link value)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- ras_ovf  out  1  sticky: a push occurred while the RAS was full
- ras_unf  out  1  sticky: a pop occurred while the RAS was empty

Behaviour:
- Reset (rst==0 at a falling edge): pc=RESET_VECTOR, RAS count=0, top pointer=0, ras_ovf=0, ras_unf=0. Reset overrides every other input. An active call or ret is abandoned.
- Priority per edge: reset > stall > ret > redirect > sequential.
- stall=1: pc, RAS contents, count and sticky flags all hold. Other inputs are ignored.
- ret=1, call=0:
  - RAS non-empty: pc=top entry, count-1.
  - RAS empty: pc=pc_plus, ras_unf=1.
  - redirect is ignored.
- ret=1, call=1 (coroutine swap): pc=top entry and the top entry is replaced by pc_plus. Count is unchanged.
  - If the RAS is empty: pc=pc_plus, ras_unf=1, no push.
- redirect=1, ret=0: pc=redirect_target.
  - If call=1, pc_plus is also pushed.
  - Push on a full RAS overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_ovf=1.
- call=1 without redirect or ret: ignored, no push.
- Otherwise: pc=pc+INCR.
- Address arithmetic is modulo 2^ADDR_W. pc+INCR wraps from all-ones region to low addresses without any flag.
- Latency: inputs sampled at falling edge N are reflected on pc immediately after edge N (one-edge latency).
- RAS: circular buffer with top pointer of clog2(RAS_DEPTH) bits, wrapping. The count saturates at RAS_DEPTH.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, sticky, reset 0).
  - A redirect target, or a popped RAS value, with address bits below log2(INCR) nonzero loads pc=TRAP_VECTOR and sets misalign.
  - The associated push or pop still occurs.
- Undefined: targets are loaded unmodified and there is no misalign port.

Decomposition:
- Shared package pc_pkg holds the priority-case encoding (localparams SEL_HOLD, SEL_RET, SEL_REDIR, SEL_SEQ) and the default RESET_VECTOR and TRAP_VECTOR constants.
- One sub-module, ras_stack: the circular buffer with push, pop, swap, count, full/empty and the sticky flags.
- pc_unit holds the pc register and next-pc selection.

Test Plan:
- Hold rst=0 two edges, then release → pc=0, ras_empty=1, flags 0. Free-run 3 edges → pc=4, 8, 12.
- At pc=0x10, pulse stall one edge → pc stays 0x10. The next edge → 0x14.
- At pc=0x20: redirect=1, call=1, target=0x100 → pc=0x100, pushed 0x24. Then ret=1 → pc=0x24, ras_empty=1.
- Five calls with RAS_DEPTH=4 (from 0x0, 0x40, 0x80, 0xC0, 0x100) → ras_full=1, ras_ovf=1. Four rets return 0x104, 0xC4, 0x84, 0x44. A fifth ret → pc advances by 4, ras_unf=1.
- ret and redirect together with RAS top=0x200 → pc=0x200 (ret wins). ret and call together → pc=0x200, new top=old pc+4, count unchanged.
- Drive rst=0 mid-call (redirect+call asserted) → pc=RESET_VECTOR, RAS empty, no push. With PC_MISALIGN_TRAP_EN, redirect to 0x102 → pc=0x80, misalign=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: next-pc source encoding and default vectors.
// Combinational helper only; no state and no flow control.
package pc_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_RET   = 2'd1;
  localparam logic [1:0] SEL_REDIR = 2'd2;
  localparam logic [1:0] SEL_SEQ   = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

  // Fixed priority: stall > ret > redirect > sequential.
  function automatic logic [1:0] pc_sel(input logic stall, input logic ret,
                                        input logic redirect);
    if (stall)         return SEL_HOLD;
    else if (ret)      return SEL_RET;
    else if (redirect) return SEL_REDIR;
    else               return SEL_SEQ;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with push/pop/swap and sticky overflow/underflow flags.
// Updates on the falling clock edge; a push on a full stack overwrites the oldest entry.
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         swap,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top_dat,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [PW-1:0] top_idx;

  // top_q is the next write slot, so the live top sits one below it.
  assign top_idx = top_q - PW'(1);
  assign top_dat = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign ovf     = ovf_q;
  assign unf     = unf_q;

  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      mem_d[top_q] = push_dat;
      top_d        = top_q + PW'(1);
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
    end else if (swap) begin
      if (empty) unf_d = 1'b1;
      else       mem_d[top_idx] = push_dat;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents need no reset: the count gates every read that matters.
  always_ff @(negedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential/stall/redirect/call/return selection; pc updates one falling edge after inputs.
// No backpressure; stall holds all state. PC_MISALIGN_TRAP_EN adds misaligned-target trapping and a misalign flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                INCR         = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(DEFAULT_TRAP_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ras_top;
  logic [1:0]        sel;
  logic              ras_push, ras_pop, ras_swap;

  assign sel     = pc_sel(stall, ret, redirect);
  assign pc      = pc_q;
  assign pc_plus = pc_q + ADDR_W'(INCR);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INCR - 1);
  logic misalign_q, misalign_d;
  logic load_chk;
  assign misalign = misalign_q;
`endif

  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_swap = 1'b0;
    case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET: begin
        // ret with call is a coroutine swap: jump to top, leave the link in its place.
        ras_pop  = !call;
        ras_swap = call;
        pc_d     = ras_empty ? pc_plus : ras_top;
      end
      SEL_REDIR: begin
        ras_push = call;
        pc_d     = redirect_target;
      end
      default: pc_d = pc_plus;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
    load_chk   = (sel == SEL_REDIR) || ((sel == SEL_RET) && !ras_empty);
    if (load_chk && |(pc_d & ALIGN_MASK)) begin
      pc_d       = TRAP_VECTOR;
      misalign_d = 1'b1;
    end
`endif
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(negedge clk) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end
`endif

  ras_stack #(
    .W    (ADDR_W),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (ras_push),
    .pop     (ras_pop),
    .swap    (ras_swap),
    .push_dat(pc_plus),
    .top_dat (ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf     (ras_ovf),
    .unf     (ras_unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: driver queues expected state per edge, monitor compares after each falling edge.
module tb_pc_unit;

  logic        clk;
  logic        rst, stall, redirect, call, ret;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_plus;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .call           (call),
    .ret            (ret),
    .pc             (pc),
    .pc_plus        (pc_plus),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_ovf        (ras_ovf),
    .ras_unf        (ras_unf)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign       (misalign)
`endif
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          idx;
    logic        r, st, rd, c, rt;
    logic [31:0] tg;
    logic [31:0] pc;
    logic        e, f, o, u, m;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, st, rd, c, rt, input logic [31:0] tg,
                     input logic [31:0] epc, input logic e, f, o, u, m);
    vec_t v;
    v.idx = vecs.size() + 1;
    v.r = r; v.st = st; v.rd = rd; v.c = c; v.rt = rt; v.tg = tg;
    v.pc = epc; v.e = e; v.f = f; v.o = o; v.u = u; v.m = m;
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d.%s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  // Monitor: one output per falling edge; compare against the oldest queued expectation.
  initial begin
    vec_t v;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        v = exp_q.pop_front();
        chk(v.idx, "pc", pc, v.pc);
        chk(v.idx, "pc_plus", pc_plus, v.pc + 32'd4);
        chk(v.idx, "ras_empty", {31'b0, ras_empty}, {31'b0, v.e});
        chk(v.idx, "ras_full", {31'b0, ras_full}, {31'b0, v.f});
        chk(v.idx, "ras_ovf", {31'b0, ras_ovf}, {31'b0, v.o});
        chk(v.idx, "ras_unf", {31'b0, ras_unf}, {31'b0, v.u});
`ifdef PC_MISALIGN_TRAP_EN
        chk(v.idx, "misalign", {31'b0, misalign}, {31'b0, v.m});
`endif
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; call = 1'b0; ret = 1'b0;
    redirect_target = '0;

    //   r  st rd c  rt  target         pc            e  f  o  u  m
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h4,        1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h8,        1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'hC,        1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h10,       1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 32'h0,        32'h10,       1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h14,       1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h18,       1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h1C,       1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h20,       1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 32'h100,      32'h100,      0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'h24,       1, 0, 0, 0, 0);
    // five nested calls into a four-deep stack
    add(1, 0, 1, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 32'h40,       32'h40,       0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 32'h80,       32'h80,       0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 32'hC0,       32'hC0,       0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 32'h100,      32'h100,      0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 0, 32'h200,      32'h200,      0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'h104,      0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'hC4,       0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'h84,       0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'h44,       1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'h48,       1, 0, 1, 1, 0);
    // ret beats redirect; stall holds a pending ret
    add(1, 0, 1, 0, 0, 32'h1FC,      32'h1FC,      1, 0, 1, 1, 0);
    add(1, 0, 1, 1, 0, 32'h300,      32'h300,      0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 1, 32'h0,        32'h300,      0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 1, 32'h500,      32'h200,      1, 0, 1, 1, 0);
    // coroutine swap, then pop the swapped-in link
    add(1, 0, 1, 0, 0, 32'h1FC,      32'h1FC,      1, 0, 1, 1, 0);
    add(1, 0, 1, 1, 0, 32'h300,      32'h300,      0, 0, 1, 1, 0);
    add(1, 0, 0, 1, 1, 32'h0,        32'h200,      0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'h304,      1, 0, 1, 1, 0);
    add(1, 0, 0, 1, 0, 32'h0,        32'h308,      1, 0, 1, 1, 0);
    add(1, 0, 0, 1, 1, 32'h0,        32'h30C,      1, 0, 1, 1, 0);
    // reset during a call abandons the push
    add(0, 0, 1, 1, 0, 32'h700,      32'h0,        1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 32'h0,        32'h4,        1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 32'h102,      TRAP ? 32'h80 : 32'h102, 1, 0, 0, 0, TRAP);
    add(1, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0, TRAP);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, TRAP);

    foreach (vecs[i]) begin
      @(posedge clk);
      rst = vecs[i].r; stall = vecs[i].st; redirect = vecs[i].rd;
      call = vecs[i].c; ret = vecs[i].rt; redirect_target = vecs[i].tg;
      exp_q.push_back(vecs[i]);
    end
    @(posedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; call = 1'b0; ret = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
